// File: rtl/bomb_slot_ctrl.sv
// bomb_slot_ctrl: per-player bomb manager with debounced placement and three fuse/blast slots
module bomb_slot_ctrl #(
  parameter int FUSE_CYCLES     = 100_000_000,
  parameter int BLAST_CYCLES    = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int GRID_W          = 39,
  parameter int GRID_H          = 29
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bomb_btn,
  input  logic [9:0]  px_cell,
  input  logic [9:0]  py_cell,
  input  logic [2:0]  chain_hit,
  output logic [17:0] bomb_x,
  output logic [17:0] bomb_y,
  output logic [2:0]  blast,
  output logic        place_ack,
  output logic [1:0]  slots_free
);
  localparam int CW = $clog2(FUSE_CYCLES > BLAST_CYCLES ? FUSE_CYCLES : BLAST_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {S_IDLE, S_FUSE, S_BLAST} state_t;
  logic          r_s1, r_s2, r_stable;
  logic [DW-1:0] r_dcnt;
  logic          w_deb_done, w_press, w_dup, w_ok;
  logic [2:0]    w_idle;
  logic [1:0]    w_sel, w_free_n;
  state_t        r_st [3];
  state_t        w_st_n [3];
  logic [CW-1:0] r_cnt [3];
  logic [CW-1:0] w_cnt_n [3];
  logic [5:0]    r_x [3];
  logic [5:0]    r_y [3];
  logic [5:0]    w_x_n [3];
  logic [5:0]    w_y_n [3];
  logic          r_ack;
  logic [1:0]    r_free;
  assign w_deb_done = (r_s2 != r_stable) && (r_dcnt == DW'(DEBOUNCE_CYCLES - 1));
  assign w_press    = w_deb_done && r_s2;
  // Reset treats the button as already pressed so a held button must be released first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_stable <= 1'b1;
      r_dcnt   <= '0;
    end else begin
      r_s1   <= bomb_btn;
      r_s2   <= r_s1;
      r_dcnt <= (r_s2 == r_stable || w_deb_done) ? '0 : r_dcnt + 1'b1;
      if (w_deb_done) r_stable <= r_s2;
    end
  end
  always_comb begin
    w_dup  = 1'b0;
    w_idle = '0;
    for (int i = 0; i < 3; i++) begin
      w_idle[i] = r_st[i] == S_IDLE;
      w_dup     = w_dup | (r_st[i] == S_FUSE && r_x[i] == px_cell[5:0] && r_y[i] == py_cell[5:0]);
    end
  end
  assign w_sel = w_idle[0] ? 2'd0 : w_idle[1] ? 2'd1 : 2'd2;
  assign w_ok  = w_press && |w_idle && px_cell < 10'(GRID_W) && py_cell < 10'(GRID_H) && !w_dup;
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_st_n[i]  = r_st[i];
      w_cnt_n[i] = '0;
      w_x_n[i]   = r_x[i];
      w_y_n[i]   = r_y[i];
      if (r_st[i] == S_FUSE) begin
        if (r_cnt[i] == CW'(FUSE_CYCLES - 1) || chain_hit[i]) w_st_n[i] = S_BLAST;
        else w_cnt_n[i] = r_cnt[i] + 1'b1;
      end else if (r_st[i] == S_BLAST) begin
        if (r_cnt[i] == CW'(BLAST_CYCLES - 1)) begin
          w_st_n[i] = S_IDLE;
          w_x_n[i]  = 6'h3F;
          w_y_n[i]  = 6'h3F;
        end else w_cnt_n[i] = r_cnt[i] + 1'b1;
      end else if (w_ok && w_sel == 2'(i)) begin
        w_st_n[i] = S_FUSE;
        w_x_n[i]  = px_cell[5:0];
        w_y_n[i]  = py_cell[5:0];
      end
    end
  end
  assign w_free_n = {1'b0, w_st_n[0] == S_IDLE} + {1'b0, w_st_n[1] == S_IDLE} + {1'b0, w_st_n[2] == S_IDLE};
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        r_st[i]  <= S_IDLE;
        r_cnt[i] <= '0;
        r_x[i]   <= 6'h3F;
        r_y[i]   <= 6'h3F;
      end
      r_ack  <= 1'b0;
      r_free <= 2'd3;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_st[i]  <= w_st_n[i];
        r_cnt[i] <= w_cnt_n[i];
        r_x[i]   <= w_x_n[i];
        r_y[i]   <= w_y_n[i];
      end
      r_ack  <= w_ok;
      r_free <= w_free_n;
    end
  end
  assign bomb_x     = {r_x[0], r_x[1], r_x[2]};
  assign bomb_y     = {r_y[0], r_y[1], r_y[2]};
  assign blast      = {r_st[2] == S_BLAST, r_st[1] == S_BLAST, r_st[0] == S_BLAST};
  assign place_ack  = r_ack;
  assign slots_free = r_free;
endmodule

// File: tb/tb_bomb_slot_ctrl.sv
// tb_bomb_slot_ctrl: directed checks of debounce, placement, fuse/blast timing and reset
module tb_bomb_slot_ctrl;
  logic        clk = 1'b0, reset = 1'b1, bomb_btn = 1'b0;
  logic [9:0]  px_cell = '0, py_cell = '0;
  logic [2:0]  chain_hit = '0;
  logic [17:0] bomb_x, bomb_y;
  logic [2:0]  blast;
  logic        place_ack;
  logic [1:0]  slots_free;
  int cyc = 0, n_chk = 0, n_fail = 0, ack_cyc = 0, ta, tb, a, w, h;
  int rise [3];
  int hi [3];
  bomb_slot_ctrl #(.FUSE_CYCLES(20), .BLAST_CYCLES(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .bomb_btn(bomb_btn), .px_cell(px_cell), .py_cell(py_cell),
    .chain_hit(chain_hit), .bomb_x(bomb_x), .bomb_y(bomb_y), .blast(blast),
    .place_ack(place_ack), .slots_free(slots_free)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1; bomb_btn = 1'b0; chain_hit = '0;
    step(); step();
    reset = 1'b0;
    repeat (10) step();
  endtask
  task automatic press(input int x, input int y, input int hold, input int trail, output int acks);
    px_cell = 10'(x); py_cell = 10'(y); bomb_btn = 1'b1; acks = 0;
    repeat (hold) begin
      step();
      if (place_ack) begin acks++; ack_cyc = cyc; end
    end
    bomb_btn = 1'b0;
    repeat (trail) begin
      step();
      if (place_ack) begin acks++; ack_cyc = cyc; end
    end
  endtask
  task automatic clr();
    for (int k = 0; k < 3; k++) begin rise[k] = -1; hi[k] = 0; end
  endtask
  task automatic watch(input int n);
    repeat (n) begin
      step();
      for (int k = 0; k < 3; k++) if (blast[k]) begin
        if (hi[k] == 0) rise[k] = cyc;
        hi[k]++;
      end
    end
  endtask
  initial begin
    // 1: reset values, single placement, fuse and blast durations
    step(); step();
    check("rst_x", bomb_x, 18'h3FFFF);
    check("rst_y", bomb_y, 18'h3FFFF);
    check("rst_blast", blast, 0);
    check("rst_ack", place_ack, 0);
    check("rst_free", slots_free, 3);
    reset = 1'b0;
    repeat (10) step();
    press(3, 5, 10, 8, a);
    check("t1_ack", a, 1);
    check("t1_x", bomb_x[17:12], 3);
    check("t1_y", bomb_y[17:12], 5);
    check("t1_free", slots_free, 2);
    w = 0;
    while (!blast[0] && w < 100) begin step(); w++; end
    check("t1_fuse", cyc - ack_cyc, 20);
    h = 0;
    while (blast[0] && h < 100) begin h++; step(); end
    check("t1_blast_len", h, 8);
    check("t1_x_empty", bomb_x[17:12], 6'h3F);
    check("t1_free_end", slots_free, 3);
    // 2: fill all slots; 4th press lands while slot0 finishes its blast
    do_reset();
    press(1, 1, 4, 5, a); check("t2_ack0", a, 1); check("t2_free0", slots_free, 2);
    press(3, 1, 4, 5, a); check("t2_ack1", a, 1); check("t2_free1", slots_free, 1);
    press(5, 1, 4, 5, a); check("t2_ack2", a, 1); check("t2_free2", slots_free, 0);
    check("t2_x", bomb_x, {6'd1, 6'd3, 6'd5});
    check("t2_y", bomb_y, {6'd1, 6'd1, 6'd1});
    check("t2_blast", blast, 3'b001);
    press(7, 1, 4, 5, a); check("t2_ack3", a, 0);
    check("t2_x0_empty", bomb_x[17:12], 6'h3F);
    check("t2_free3", slots_free, 1);
    // 3: duplicate cell while in fuse
    do_reset();
    press(9, 9, 4, 5, a); check("t3_ack0", a, 1);
    press(9, 9, 4, 5, a); check("t3_dup", a, 0);
    check("t3_x1", bomb_x[11:6], 6'h3F);
    check("t3_free", slots_free, 2);
    // 4: chain hit on slot1 at fuse count 5; idle slot2 ignores it
    do_reset();
    press(2, 2, 4, 5, a); ta = ack_cyc;
    press(4, 4, 4, 5, a); tb = ack_cyc;
    step(); step();
    clr();
    chain_hit = 3'b110;
    watch(1);
    chain_hit = '0;
    watch(30);
    check("t4_chain_rise", rise[1] - tb, 6);
    check("t4_chain_len", hi[1], 8);
    check("t4_s0_rise", rise[0] - ta, 20);
    check("t4_s0_len", hi[0], 8);
    check("t4_idle_chain", hi[2], 0);
    // 5: bouncing button then a clean hold
    do_reset();
    px_cell = 10'd6; py_cell = 10'd6; a = 0;
    for (int i = 0; i < 16; i++) begin
      bomb_btn = (i < 2 || (i >= 4 && i < 6));
      step();
      if (place_ack) a++;
    end
    check("t5_bounce", a, 0);
    press(6, 6, 6, 8, a); check("t5_clean", a, 1);
    // 6: reset mid-fuse and mid-blast, button held across reset
    do_reset();
    press(1, 2, 4, 5, a);
    press(3, 4, 4, 5, a);
    repeat (10) step();
    check("t6_pre_blast", blast, 3'b001);
    bomb_btn = 1'b1; reset = 1'b1;
    step();
    check("t6_x", bomb_x, 18'h3FFFF);
    check("t6_y", bomb_y, 18'h3FFFF);
    check("t6_blast", blast, 0);
    check("t6_ack", place_ack, 0);
    check("t6_free", slots_free, 3);
    reset = 1'b0; a = 0;
    repeat (20) begin step(); if (place_ack) a++; end
    check("t6_held", a, 0);
    bomb_btn = 1'b0;
    repeat (10) step();
    press(5, 5, 6, 8, a); check("t6_repress", a, 1);
    // 7: grid bounds
    do_reset();
    press(39, 5, 6, 8, a); check("t7_x_oob", a, 0);
    press(5, 29, 6, 8, a); check("t7_y_oob", a, 0);
    press(38, 28, 6, 8, a); check("t7_edge", a, 1);
    check("t7_x", bomb_x[17:12], 38);
    check("t7_y", bomb_y[17:12], 28);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
